// File: rtl/aibcr3_scan_chain_ctrl_if.sv
// Request/scan bundle between a scan-chain requester and aibcr3_scan_chain_ctrl.
// UNLOAD_PAR exists only when AIBCR3_SCAN_CTRL_PAR_EN is defined.
interface aibcr3_scan_chain_ctrl_if #(
  parameter int CHAIN_LEN = 16
);
  logic                 START;
  logic                 CAPTURE_EN;
  logic                 FILL;
  logic [CHAIN_LEN-1:0] LOAD_DATA;
  logic                 SO;
  logic                 SE;
  logic                 SI;
  logic                 BUSY;
  logic                 DONE;
  logic [CHAIN_LEN-1:0] UNLOAD_DATA;
`ifdef AIBCR3_SCAN_CTRL_PAR_EN
  logic                 UNLOAD_PAR;
`endif

  // master: requester plus chain model; slave: the controller
  modport master (
    output START, CAPTURE_EN, FILL, LOAD_DATA, SO,
    input  SE, SI, BUSY, DONE, UNLOAD_DATA
`ifdef AIBCR3_SCAN_CTRL_PAR_EN
    , input UNLOAD_PAR
`endif
  );

  modport slave (
    input  START, CAPTURE_EN, FILL, LOAD_DATA, SO,
    output SE, SI, BUSY, DONE, UNLOAD_DATA
`ifdef AIBCR3_SCAN_CTRL_PAR_EN
    , output UNLOAD_PAR
`endif
  );
endinterface

// File: rtl/aibcr3_scan_chain_ctrl.sv
// Serial load / optional capture / unload driver for an aibcr3 mux-scan chain.
// Define AIBCR3_SCAN_CTRL_PAR_EN to add the serially accumulated UNLOAD_PAR output.
module aibcr3_scan_chain_ctrl #(
  parameter  int CHAIN_LEN = 16,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input logic                     CK,
  input logic                     RST,
  aibcr3_scan_chain_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_IN,
    ST_CAPTURE,
    ST_SHIFT_OUT,
    ST_FINISH
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  state_t               state_q,  state_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [CHAIN_LEN-1:0] load_q,   load_d;
  logic                 cap_q,    cap_d;
  logic                 fill_q,   fill_d;
  logic                 se_q,     se_d;
  logic                 si_q,     si_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;
  logic [CHAIN_LEN-1:0] unload_q, unload_d;
`ifdef AIBCR3_SCAN_CTRL_PAR_EN
  logic                 par_q,    par_d;
`endif

  logic                 cnt_last;
  logic                 unload_en;
  logic [CHAIN_LEN-1:0] load_shift;
  logic [CHAIN_LEN-1:0] unload_shift;

  assign cnt_last = (cnt_q == CNT_LAST);

  // load_q always holds the bits still to be sent, next one at the MSB
  assign load_shift[0]   = 1'b0;
  assign unload_shift[0] = bus.SO;
  for (genvar gi = 1; gi < CHAIN_LEN; gi++) begin : g_shift
    assign load_shift[gi]   = load_q[gi-1];
    assign unload_shift[gi] = unload_q[gi-1];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_d    = load_q;
    cap_d     = cap_q;
    fill_d    = fill_q;
    se_d      = se_q;
    si_d      = si_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unload_d  = unload_q;
`ifdef AIBCR3_SCAN_CTRL_PAR_EN
    par_d     = par_q;
`endif
    unload_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        se_d   = 1'b0;
        si_d   = 1'b0;
        busy_d = 1'b0;
        if (bus.START) begin
          state_d  = ST_SHIFT_IN;
          load_d   = bus.LOAD_DATA << 1;
          cap_d    = bus.CAPTURE_EN;
          fill_d   = bus.FILL;
          cnt_d    = '0;
          unload_d = '0;
`ifdef AIBCR3_SCAN_CTRL_PAR_EN
          par_d    = 1'b0;
`endif
          se_d     = 1'b1;
          si_d     = bus.LOAD_DATA[CHAIN_LEN-1];
          busy_d   = 1'b1;
        end
      end

      ST_SHIFT_IN: begin
        load_d    = load_shift;
        unload_en = !cap_q;
        if (cnt_last) begin
          cnt_d = '0;
          se_d  = 1'b0;
          si_d  = 1'b0;
          if (cap_q) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          si_d  = load_q[CHAIN_LEN-1];
        end
      end

      ST_CAPTURE: begin
        state_d = ST_SHIFT_OUT;
        se_d    = 1'b1;
        si_d    = fill_q;
      end

      ST_SHIFT_OUT: begin
        unload_en = 1'b1;
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = ST_FINISH;
          se_d    = 1'b0;
          si_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
        se_d    = 1'b0;
        si_d    = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        se_d    = 1'b0;
        si_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // SO is sampled on the same edge the chain shifts, i.e. before its update
    if (unload_en) begin
      unload_d = unload_shift;
`ifdef AIBCR3_SCAN_CTRL_PAR_EN
      par_d    = par_q ^ bus.SO;
`endif
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      load_q   <= '0;
      cap_q    <= 1'b0;
      fill_q   <= 1'b0;
      se_q     <= 1'b0;
      si_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      unload_q <= '0;
`ifdef AIBCR3_SCAN_CTRL_PAR_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      cap_q    <= cap_d;
      fill_q   <= fill_d;
      se_q     <= se_d;
      si_q     <= si_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      unload_q <= unload_d;
`ifdef AIBCR3_SCAN_CTRL_PAR_EN
      par_q    <= par_d;
`endif
    end
  end

  assign bus.SE          = se_q;
  assign bus.SI          = si_q;
  assign bus.BUSY        = busy_q;
  assign bus.DONE        = done_q;
  assign bus.UNLOAD_DATA = unload_q;
`ifdef AIBCR3_SCAN_CTRL_PAR_EN
  assign bus.UNLOAD_PAR  = par_q;
`endif

endmodule

// File: tb/tb_aibcr3_scan_chain_ctrl.sv
// Bench for aibcr3_scan_chain_ctrl: 16-flop and 2-flop behavioural chains,
// expectations built from operation-level rules (which word ends where, when DONE fires).
`timescale 1ns/1ps
module tb_aibcr3_scan_chain_ctrl;
  localparam int N = 16;
  localparam int M = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  aibcr3_scan_chain_ctrl_if #(.CHAIN_LEN(N)) bus16 ();
  aibcr3_scan_chain_ctrl_if #(.CHAIN_LEN(M)) bus2 ();

  aibcr3_scan_chain_ctrl #(.CHAIN_LEN(N)) dut16 (.CK(clk), .RST(rst), .bus(bus16));
  aibcr3_scan_chain_ctrl #(.CHAIN_LEN(M)) dut2  (.CK(clk), .RST(rst), .bus(bus2));

  // behavioural scan chains: shift when SE, optional functional capture otherwise
  logic [N-1:0] chain16, pre16_val = '0, func16_d = '0;
  logic         pre16_req = 1'b0, func16_en = 1'b0;
  logic [M-1:0] chain2, pre2_val = '0, func2_d = '0;
  logic         pre2_req = 1'b0, func2_en = 1'b0;

  always @(posedge clk) begin
    if (pre16_req)            chain16 <= pre16_val;
    else if (bus16.SE === 1'b1) chain16 <= {chain16[N-2:0], bus16.SI};
    else if (func16_en)       chain16 <= func16_d;
  end
  always @(posedge clk) begin
    if (pre2_req)             chain2 <= pre2_val;
    else if (bus2.SE === 1'b1) chain2 <= {chain2[M-2:0], bus2.SI};
    else if (func2_en)        chain2 <= func2_d;
  end
  assign bus16.SO = chain16[N-1];
  assign bus2.SO  = chain2[M-1];

  // per-interval trace of the 16-flop run; interval i lies between e_i and e_i+1
  logic [79:0]  tr_se, tr_si, tr_busy;
  int           done_at;
  logic [N-1:0] unl_at_done, chain_at_done;
  logic         par_at_done;
  logic [79:0]  exp_se, exp_si, exp_busy;
  int           exp_done;

  task automatic preload16(input logic [N-1:0] v);
    @(negedge clk);
    pre16_req = 1'b1;
    pre16_val = v;
    @(negedge clk);
    pre16_req = 1'b0;
  endtask

  task automatic run16(input logic [N-1:0] ld, input logic cap, input logic fill,
                       input int pa, input int pb, input int rst_at);
    tr_se = '0; tr_si = '0; tr_busy = '0; done_at = -1; par_at_done = 1'b0;
    @(negedge clk);
    bus16.LOAD_DATA = ld; bus16.CAPTURE_EN = cap; bus16.FILL = fill; bus16.START = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      bus16.LOAD_DATA = ~ld; bus16.CAPTURE_EN = ~cap; bus16.FILL = ~fill;
      tr_se[i] = bus16.SE; tr_si[i] = bus16.SI; tr_busy[i] = bus16.BUSY;
      bus16.START = (i == pa || i == pb);
      if (bus16.DONE === 1'b1) begin
        done_at = i;
        unl_at_done = bus16.UNLOAD_DATA;
        chain_at_done = chain16;
`ifdef AIBCR3_SCAN_CTRL_PAR_EN
        par_at_done = bus16.UNLOAD_PAR;
`endif
        func16_en = 1'b0;
        break;
      end
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        break;
      end
    end
    bus16.START = 1'b0;
  endtask

  // expected waveform derived from the phase lengths of one operation
  function automatic void build_exp16(input logic [N-1:0] ld, input logic cap, input logic fill);
    exp_se = '0; exp_si = '0; exp_busy = '0;
    for (int i = 0; i < N; i++) begin
      exp_se[i] = 1'b1; exp_si[i] = ld[N-1-i]; exp_busy[i] = 1'b1;
    end
    if (cap) begin
      exp_busy[N] = 1'b1;
      for (int i = N + 1; i <= 2 * N; i++) begin
        exp_se[i] = 1'b1; exp_si[i] = fill; exp_busy[i] = 1'b1;
      end
      exp_done = 2 * N + 1;
    end else begin
      exp_done = N;
    end
  endfunction

  task automatic test_reset();
    bus16.START = 0; bus16.CAPTURE_EN = 0; bus16.FILL = 0; bus16.LOAD_DATA = '0;
    bus2.START = 0;  bus2.CAPTURE_EN = 0;  bus2.FILL = 0;  bus2.LOAD_DATA = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus16.SE, bus16.SI, bus16.BUSY, bus16.DONE} !== 4'b0) begin
      failures++; $display("FAIL reset_ctrl16: se/si/busy/done=%b required 0000", {bus16.SE, bus16.SI, bus16.BUSY, bus16.DONE});
    end
    checks++;
    if (bus16.UNLOAD_DATA !== '0) begin
      failures++; $display("FAIL reset_unload16: got %h required 0000", bus16.UNLOAD_DATA);
    end
    checks++;
    if ({bus2.SE, bus2.SI, bus2.BUSY, bus2.DONE, bus2.UNLOAD_DATA} !== 6'b0) begin
      failures++; $display("FAIL reset_dut2: got %b required 000000", {bus2.SE, bus2.SI, bus2.BUSY, bus2.DONE, bus2.UNLOAD_DATA});
    end
`ifdef AIBCR3_SCAN_CTRL_PAR_EN
    checks++;
    if (bus16.UNLOAD_PAR !== 1'b0) begin
      failures++; $display("FAIL reset_par: got %b required 0", bus16.UNLOAD_PAR);
    end
`endif
    rst = 1'b0;
    $display("reset: done");
  endtask

  task automatic test_shift_only();
    preload16(16'hA5C3);
    func16_en = 1'b0;
    run16(16'h1234, 1'b0, 1'b0, -1, -1, -1);
    build_exp16(16'h1234, 1'b0, 1'b0);
    checks++;
    if (done_at !== 16) begin failures++; $display("FAIL shift_done_at: got %0d required 16", done_at); end
    checks++;
    if (tr_se !== exp_se || $countones(tr_se) != 16) begin
      failures++; $display("FAIL shift_se_trace: got %h required %h", tr_se, exp_se);
    end
    checks++;
    if ((tr_si & exp_se) !== exp_si) begin
      failures++; $display("FAIL shift_si_trace: got %h required %h", tr_si & exp_se, exp_si);
    end
    checks++;
    if (tr_busy !== exp_busy) begin failures++; $display("FAIL shift_busy_trace: got %h required %h", tr_busy, exp_busy); end
    checks++;
    if (unl_at_done !== 16'hA5C3) begin failures++; $display("FAIL shift_unload: got %h required a5c3", unl_at_done); end
    checks++;
    if (chain_at_done !== 16'h1234) begin failures++; $display("FAIL shift_chain: got %h required 1234", chain_at_done); end
    @(negedge clk);
    checks++;
    if (bus16.DONE !== 1'b0 || bus16.BUSY !== 1'b0) begin
      failures++; $display("FAIL shift_done_pulse: done/busy=%b%b required 00", bus16.DONE, bus16.BUSY);
    end
    $display("shift_only: load=1234 unload=%h done_at=%0d", unl_at_done, done_at);
  endtask

  task automatic test_capture();
    preload16(16'h3C3C);
    func16_d = 16'h0F0F;
    func16_en = 1'b1;
    run16(16'hFFFF, 1'b1, 1'b1, -1, -1, -1);
    build_exp16(16'hFFFF, 1'b1, 1'b1);
    checks++;
    if (done_at !== 33) begin failures++; $display("FAIL cap_done_at: got %0d required 33", done_at); end
    checks++;
    if (tr_se !== exp_se) begin failures++; $display("FAIL cap_se_trace: got %h required %h", tr_se, exp_se); end
    checks++;
    if ((tr_si & exp_se) !== exp_si) begin failures++; $display("FAIL cap_si_trace: got %h required %h", tr_si & exp_se, exp_si); end
    checks++;
    if (tr_busy !== exp_busy) begin failures++; $display("FAIL cap_busy_trace: got %h required %h", tr_busy, exp_busy); end
    checks++;
    if (unl_at_done !== 16'h0F0F) begin failures++; $display("FAIL cap_unload: got %h required 0f0f", unl_at_done); end
    checks++;
    if (chain_at_done !== 16'hFFFF) begin failures++; $display("FAIL cap_chain: got %h required ffff", chain_at_done); end
    $display("capture: d=0f0f unload=%h done_at=%0d", unl_at_done, done_at);
  endtask

  task automatic test_start_ignored();
    logic [N-1:0] p;
    logic         busy_seen;
    p = 16'($urandom);
    preload16(p);
    func16_en = 1'b0;
    run16(16'h6A17, 1'b0, 1'b0, 3, 10, -1);
    checks++;
    if (done_at !== 16) begin failures++; $display("FAIL ign_done_at: got %0d required 16", done_at); end
    checks++;
    if (unl_at_done !== p) begin failures++; $display("FAIL ign_unload: got %h required %h", unl_at_done, p); end
    busy_seen = 1'b0;
    repeat (N + 4) begin
      @(negedge clk);
      if (bus16.BUSY !== 1'b0 || bus16.DONE !== 1'b0 || bus16.UNLOAD_DATA !== p) busy_seen = 1'b1;
    end
    checks++;
    if (busy_seen) begin failures++; $display("FAIL ign_queued_op: extra activity or unload change seen, required none"); end
    $display("start_ignored: unload=%h done_at=%0d", unl_at_done, done_at);
  endtask

  task automatic test_mid_reset();
    logic done_seen;
    logic [N-1:0] p;
    preload16(16'hFFFF);
    func16_en = 1'b0;
    run16(16'h5555, 1'b0, 1'b0, -1, -1, 6);
    checks++;
    if ({bus16.SE, bus16.BUSY, bus16.DONE} !== 3'b000 || done_at != -1) begin
      failures++; $display("FAIL rst_ctrl: se/busy/done=%b done_at=%0d required 000 / -1", {bus16.SE, bus16.BUSY, bus16.DONE}, done_at);
    end
    checks++;
    if (bus16.UNLOAD_DATA !== '0) begin failures++; $display("FAIL rst_unload: got %h required 0000", bus16.UNLOAD_DATA); end
    done_seen = 1'b0;
    repeat (N + 4) begin
      @(negedge clk);
      if (bus16.DONE !== 1'b0) done_seen = 1'b1;
    end
    checks++;
    if (done_seen) begin failures++; $display("FAIL rst_no_done: DONE seen after reset, required none"); end
    p = 16'($urandom);
    preload16(p);
    run16(16'hBEEF, 1'b0, 1'b0, -1, -1, -1);
    checks++;
    if (done_at !== 16 || unl_at_done !== p || chain_at_done !== 16'hBEEF) begin
      failures++; $display("FAIL rst_recover: done_at=%0d unload=%h chain=%h required 16 %h beef", done_at, unl_at_done, chain_at_done, p);
    end
    $display("mid_reset: recovered unload=%h", unl_at_done);
  endtask

  task automatic test_chain_len2();
    logic [M-1:0] p, l, d;
    logic         cp, fl;
    logic [9:0]   si_tr;
    int           dn;
    for (int op = 0; op < 3; op++) begin
      if (op == 0) begin p = 2'b01; l = 2'b10; d = 2'b00; cp = 1'b0; fl = 1'b0; end
      else begin p = 2'($urandom); l = 2'($urandom); d = 2'($urandom); cp = op[0]; fl = 1'($urandom); end
      @(negedge clk);
      pre2_req = 1'b1; pre2_val = p; func2_d = d; func2_en = cp;
      @(negedge clk);
      pre2_req = 1'b0;
      bus2.LOAD_DATA = l; bus2.CAPTURE_EN = cp; bus2.FILL = fl; bus2.START = 1'b1;
      @(posedge clk);
      dn = -1; si_tr = '0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        bus2.START = 1'b0; bus2.LOAD_DATA = ~l;
        si_tr[i] = bus2.SI;
        if (bus2.DONE === 1'b1) begin dn = i; break; end
      end
      checks++;
      if (dn != (cp ? 2 * M + 1 : M)) begin failures++; $display("FAIL len2_done_at: op=%0d got %0d required %0d", op, dn, cp ? 2 * M + 1 : M); end
      checks++;
      if (si_tr[1:0] !== {l[0], l[1]}) begin failures++; $display("FAIL len2_si_seq: op=%0d got %b required %b", op, si_tr[1:0], {l[0], l[1]}); end
      checks++;
      if (bus2.UNLOAD_DATA !== (cp ? d : p) || chain2 !== (cp ? {M{fl}} : l)) begin
        failures++; $display("FAIL len2_data: op=%0d unload=%b chain=%b required %b %b", op, bus2.UNLOAD_DATA, chain2, cp ? d : p, cp ? {M{fl}} : l);
      end
      func2_en = 1'b0;
      $display("chain_len2: op=%0d cap=%0d unload=%b done_at=%0d", op, cp, bus2.UNLOAD_DATA, dn);
    end
  endtask

`ifdef AIBCR3_SCAN_CTRL_PAR_EN
  task automatic test_parity();
    logic [N-1:0] pv [2];
    pv[0] = 16'hA5C3; pv[1] = 16'h0001;
    for (int k = 0; k < 2; k++) begin
      preload16(pv[k]);
      func16_en = 1'b0;
      run16(16'($urandom), 1'b0, 1'b0, -1, -1, -1);
      checks++;
      if (par_at_done !== 1'(k)) begin failures++; $display("FAIL parity: unload=%h got %b required %0d", pv[k], par_at_done, k); end
      $display("parity: unload=%h par=%b", unl_at_done, par_at_done);
    end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] p, l, d, exp_unl, exp_chain;
    logic         cp, fl;
    for (int it = 0; it < 8; it++) begin
      p = 16'($urandom); l = 16'($urandom); d = 16'($urandom);
      cp = 1'($urandom); fl = 1'($urandom);
      preload16(p);
      func16_d = d; func16_en = cp;
      build_exp16(l, cp, fl);
      run16(l, cp, fl, $urandom_range(0, exp_done - 1), $urandom_range(0, exp_done - 1), -1);
      exp_unl   = cp ? d : p;
      exp_chain = cp ? {N{fl}} : l;
      checks++;
      if (done_at != exp_done || tr_se !== exp_se || tr_busy !== exp_busy || (tr_si & exp_se) !== exp_si) begin
        failures++; $display("FAIL rand_timing: it=%0d done_at=%0d required %0d se=%h required %h", it, done_at, exp_done, tr_se, exp_se);
      end
      checks++;
      if (unl_at_done !== exp_unl || chain_at_done !== exp_chain) begin
        failures++; $display("FAIL rand_data: it=%0d unload=%h chain=%h required %h %h", it, unl_at_done, chain_at_done, exp_unl, exp_chain);
      end
`ifdef AIBCR3_SCAN_CTRL_PAR_EN
      checks++;
      if (par_at_done !== ^exp_unl) begin failures++; $display("FAIL rand_par: it=%0d got %b required %b", it, par_at_done, ^exp_unl); end
`endif
      $display("random: it=%0d cap=%0d load=%h unload=%h done_at=%0d", it, cp, l, unl_at_done, done_at);
    end
  endtask

  initial begin
    test_reset();
    test_shift_only();
    test_capture();
    test_start_ignored();
    test_mid_reset();
    test_chain_len2();
`ifdef AIBCR3_SCAN_CTRL_PAR_EN
    test_parity();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
